// File: rtl/multi_word_write_packer_pkg.sv
// Shared definitions for the multi-word write packer: FSM state encodings.
package multi_word_write_packer_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_WRITE = 2'd1;
    localparam logic [STATE_W-1:0] ST_FULL  = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = ST_IDLE,
        WRITE = ST_WRITE,
        FULL  = ST_FULL
    } state_e;

endpackage

// File: rtl/multi_word_write_packer.sv
// Packs a valid/ready word stream into a multi-lane RAM, lane-fastest, one row at a time,
// then holds the buffer full until the consumer releases it.
module multi_word_write_packer
    import multi_word_write_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned NUM_WORDS  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          clear,
    input  logic                          release_buf,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(DEPTH)-1:0]      wr_addr,
    output logic [NUM_WORDS-1:0]          wr_en,
    output logic [$clog2(DEPTH+1)-1:0]    rows_valid,
    output logic                          buf_full
);

    localparam int unsigned ROW_W  = $clog2(DEPTH);
    localparam int unsigned LANE_W = $clog2(NUM_WORDS);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_WORDS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(DEPTH - 1);

    state_e                  state, state_d;
    logic [LANE_W-1:0]       lane, lane_d;
    logic [ROW_W-1:0]        row, row_d;
    logic [CNT_W-1:0]        rows_valid_d;
    logic [NUM_WORDS-1:0]    wr_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_d;
    logic [ROW_W-1:0]        wr_addr_d;
    logic                    accept;

    assign accept = in_valid & in_ready;

    // State, counters and all outputs update together from the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lane       <= '0;
            row        <= '0;
            rows_valid <= '0;
            wr_en      <= '0;
            wr_data    <= '0;
            wr_addr    <= '0;
            in_ready   <= 1'b0;
            buf_full   <= 1'b0;
        end else begin
            state      <= state_d;
            lane       <= lane_d;
            row        <= row_d;
            rows_valid <= rows_valid_d;
            wr_en      <= wr_en_d;
            wr_data    <= wr_data_d;
            wr_addr    <= wr_addr_d;
            in_ready   <= (state_d == WRITE);
            buf_full   <= (state_d == FULL);
        end
    end

    // Counters saturate on the last word; only release or clear bring them back to zero.
    always_comb begin
        state_d      = state;
        lane_d       = lane;
        row_d        = row;
        rows_valid_d = rows_valid;
        wr_en_d      = '0;
        wr_data_d    = wr_data;
        wr_addr_d    = wr_addr;

        if (clear) begin
            state_d      = IDLE;
            lane_d       = '0;
            row_d        = '0;
            rows_valid_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_d = WRITE;
                end
                WRITE: begin
                    if (accept) begin
                        wr_en_d   = NUM_WORDS'(1) << lane;
                        wr_data_d = in_data;
                        wr_addr_d = row;
                        if (lane == LAST_LANE) begin
                            rows_valid_d = rows_valid + CNT_W'(1);
                            if (row == LAST_ROW) begin
                                state_d = FULL;
                            end else begin
                                row_d  = row + ROW_W'(1);
                                lane_d = '0;
                            end
                        end else begin
                            lane_d = lane + LANE_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (release_buf) begin
                        state_d      = WRITE;
                        lane_d       = '0;
                        row_d        = '0;
                        rows_valid_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_word_write_packer.sv
// Directed bench for multi_word_write_packer (DEPTH=4, NUM_WORDS=2) with a write scoreboard.
module tb_multi_word_write_packer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int NW    = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          clear;
    logic          release_buf;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_addr;
    logic [NW-1:0] wr_en;
    logic [2:0]    rows_valid;
    logic          buf_full;

    multi_word_write_packer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_WORDS  (NW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .clear       (clear),
        .release_buf (release_buf),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wr_data     (wr_data),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .rows_valid  (rows_valid),
        .buf_full    (buf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    addr;
        logic [NW-1:0] en;
        logic [DW-1:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  m_state = 0;   // 0 idle, 1 write, 2 full
    int  m_count = 0;   // words accepted into the current buffer

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd0);
        chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
        chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
        chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        chk({tag, "_rows_valid"}, 32'(rows_valid), 32'd0);
        chk({tag, "_buf_full"},   32'(buf_full),   32'd0);
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, check at the next falling edge.
    task automatic cycle(input logic s, input logic c, input logic r, input logic v,
                         input logic [DW-1:0] d);
        logic acc;
        wr_t  e;
        start       = s;
        clear       = c;
        release_buf = r;
        in_valid    = v;
        in_data     = d;
        acc = v && (m_state == 1);
        if (c) begin
            m_state = 0;
            m_count = 0;
        end else begin
            case (m_state)
                0: if (s) m_state = 1;
                1: if (acc) begin
                    e.addr = 2'(m_count / NW);
                    e.en   = NW'(1 << (m_count % NW));
                    e.data = d;
                    sb_q.push_back(e);
                    m_count++;
                    if (m_count == DEPTH * NW) m_state = 2;
                end
                2: if (r) begin
                    m_state = 1;
                    m_count = 0;
                end
                default: m_state = 0;
            endcase
        end
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("wr_en",   32'(wr_en),   32'(e.en));
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("wr_data", 32'(wr_data), 32'(e.data));
        end else begin
            chk("wr_en_quiet", 32'(wr_en), 32'd0);
        end
        chk("in_ready",   32'(in_ready),   32'(m_state == 1));
        chk("buf_full",   32'(buf_full),   32'(m_state == 2));
        chk("rows_valid", 32'(rows_valid), 32'(m_count / NW));
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        clear       = 1'b0;
        release_buf = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Fill the whole buffer with continuous valid.
        cycle(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH * NW; i++) cycle(0, 0, 0, 1, 8'(8'h10 + i));
        chk("buf_full_after_8th", 32'(buf_full), 32'd1);

        // Held full with valid high: no acceptance, no write.
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 8'(8'h90 + i));
        cycle(0, 0, 1, 0, 8'h00);
        cycle(0, 0, 0, 1, 8'h20);
        chk("after_release_addr", 32'(wr_addr), 32'd0);
        chk("after_release_en",   32'(wr_en),   32'd1);

        // Remaining words with valid toggling every other cycle.
        for (int i = 1; i < DEPTH * NW; i++) begin
            cycle(0, 0, 0, 0, 8'hEE);
            cycle(0, 0, 0, 1, 8'(8'h20 + i));
        end
        chk("toggle_full", 32'(buf_full), 32'd1);

        // Clear from FULL, refill, then clear coincident with start on the 5th word.
        cycle(0, 1, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 8'(8'h30 + i));
        cycle(1, 1, 0, 1, 8'h34);
        chk("clear_rows_valid", 32'(rows_valid), 32'd0);
        chk("clear_wr_en",      32'(wr_en),      32'd0);
        chk("clear_in_ready",   32'(in_ready),   32'd0);
        cycle(0, 0, 0, 1, 8'h35);

        // Release outside FULL is ignored; then reset mid-fill.
        cycle(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'(8'h40 + i));
        cycle(0, 0, 1, 1, 8'h43);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        m_state = 0;
        m_count = 0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Stays idle without a new start, then resumes from row 0 lane 0.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'(8'h50 + i));
        cycle(1, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 1, 8'h60);
        cycle(0, 0, 0, 1, 8'h61);
        cycle(0, 0, 0, 0, 8'h00);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
